// File: rtl/cpu_multi_pkg.sv
// Shared definitions for the cpu_multi multicycle core: opcodes, step encoding
// and the internal bus source selector.
package cpu_multi_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVNZ = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_SLL  = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_DIN  = 3'd1,
        SEL_RX   = 3'd2,
        SEL_RY   = 3'd3,
        SEL_G    = 3'd4
    } bus_sel_t;

    // ALU ops take the four-step A/G path; everything else finishes in T1.
    function automatic logic is_alu(input logic [2:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_SLL: is_alu = 1'b1;
            default:                        is_alu = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_multi_regn.sv
// Generic W-bit register with synchronous reset and load enable, used for
// the general registers and the A/G operand/result registers.
module regn #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Hold unless loaded; reset clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/cpu_multi.sv
// Parametrised multicycle processor: one instruction per Run request, executed
// over T0..T3 with all transfers through a single internal bus.
import cpu_multi_pkg::*;

module cpu_multi #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] DIN,
    input  logic              Run,
    output logic              Done,
    output logic [DATA_W-1:0] Bus,
    output logic              Zero
);

    localparam int REG_W = $clog2(NREG);
    localparam int IR_W  = 3 + 2 * REG_W;

    state_t            state;
    state_t            next_state;
    bus_sel_t          bus_sel;
    logic [IR_W-1:0]   ir;
    logic [2:0]        op;
    logic [REG_W-1:0]  rx_sel;
    logic [REG_W-1:0]  ry_sel;
    logic [DATA_W-1:0] r_q [NREG];
    logic [NREG-1:0]   r_load;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] g_q;
    logic [DATA_W-1:0] alu_res;
    logic [4:0]        shamt;
    logic              a_load;
    logic              g_load;
    logic              ir_load;
    logic              zero_q;

    assign op     = ir[IR_W-1 -: 3];
    assign rx_sel = ir[2*REG_W-1 -: REG_W];
    assign ry_sel = ir[REG_W-1:0];
    assign shamt  = Bus[4:0];
    assign Zero   = zero_q;

    for (genvar i = 0; i < NREG; i++) begin : g_regs
        regn #(.W(DATA_W)) u_r (
            .clk(Clock), .reset(Reset), .load(r_load[i]), .d(Bus), .q(r_q[i])
        );
    end

    regn #(.W(DATA_W)) u_a (
        .clk(Clock), .reset(Reset), .load(a_load), .d(Bus), .q(a_q)
    );

    regn #(.W(DATA_W)) u_g (
        .clk(Clock), .reset(Reset), .load(g_load), .d(alu_res), .q(g_q)
    );

    // State, instruction and zero-flag registers; upper DIN bits never enter IR.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= T0;
            ir     <= '0;
            zero_q <= 1'b0;
        end else begin
            state <= next_state;
            if (ir_load) begin
                ir <= DIN[IR_W-1:0];
            end
            if (g_load) begin
                zero_q <= (alu_res == '0);
            end
        end
    end

    // Step sequencing.
    always_comb begin
        next_state = T0;
        case (state)
            T0:      next_state = Run ? T1 : T0;
            T1:      next_state = is_alu(op) ? T2 : T0;
            T2:      next_state = T3;
            T3:      next_state = T0;
            default: next_state = T0;
        endcase
    end

    // Per-step bus source, register loads and completion pulse.
    always_comb begin
        bus_sel = SEL_NONE;
        r_load  = '0;
        a_load  = 1'b0;
        g_load  = 1'b0;
        ir_load = 1'b0;
        Done    = 1'b0;
        case (state)
            T0: ir_load = Run;
            T1: begin
                if (is_alu(op)) begin
                    bus_sel = SEL_RX;
                    a_load  = 1'b1;
                end else begin
                    Done = 1'b1;
                    case (op)
                        OP_MV: begin
                            bus_sel        = SEL_RY;
                            r_load[rx_sel] = 1'b1;
                        end
                        OP_MVI: begin
                            bus_sel        = SEL_DIN;
                            r_load[rx_sel] = 1'b1;
                        end
                        OP_MVNZ: begin
                            bus_sel = SEL_RY;
                            if (g_q != '0) begin
                                r_load[rx_sel] = 1'b1;
                            end else begin
                                r_load = '0;
                            end
                        end
                        default: bus_sel = SEL_NONE;
                    endcase
                end
            end
            T2: begin
                bus_sel = SEL_RY;
                g_load  = 1'b1;
            end
            T3: begin
                bus_sel        = SEL_G;
                r_load[rx_sel] = 1'b1;
                Done           = 1'b1;
            end
            default: bus_sel = SEL_NONE;
        endcase
    end

    // ALU: A is the first operand, the bus carries Ry during T2.
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD: alu_res = a_q + Bus;
            OP_SUB: alu_res = a_q - Bus;
            OP_AND: alu_res = a_q & Bus;
            OP_SLL: begin
                if ({27'd0, shamt} >= 32'(DATA_W)) begin
                    alu_res = '0;
                end else begin
                    alu_res = a_q << shamt;
                end
            end
            default: alu_res = '0;
        endcase
    end

    // Bus multiplexer; unselected steps drive zero.
    always_comb begin
        Bus = '0;
        case (bus_sel)
            SEL_DIN:  Bus = DIN;
            SEL_RX:   Bus = r_q[rx_sel];
            SEL_RY:   Bus = r_q[ry_sel];
            SEL_G:    Bus = g_q;
            default:  Bus = '0;
        endcase
    end

endmodule
